popcount_stream: RTL and testbench

- Streaming, parametrised population counter; successor to the 8-bit combinational bit counter.
- Takes DATA_W-bit words over a valid/ready handshake and returns a set-bit count either per word or accumulated over a packet delimited by a last flag.
- Two-stage pipeline with backpressure; saturating accumulator with sticky saturation flag.
- Sits between a data source (e.g. a memory scan) and a consumer of statistics.

---
 rtl/popcount_pkg.sv | 37 +++
 rtl/popcount_stream_if.sv | 29 ++
 rtl/popcount_chunk.sv | 19 +
 rtl/popcount_stream.sv | 138 +++++++++++++
 tb/tb_popcount_stream.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared definitions for the streaming popcount: widths, mode encoding and
// the width helpers each instance uses to size its counters.
package popcount_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_CHUNK_W = 8;
    localparam int unsigned DEF_ACC_W   = 16;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    // Smallest r such that 2**r >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic int unsigned calc_chunks(input int unsigned data_w,
                                                input int unsigned chunk_w);
        return data_w / chunk_w;
    endfunction

    function automatic int unsigned calc_chunk_cnt_w(input int unsigned chunk_w);
        return clog2(chunk_w + 1);
    endfunction

    function automatic int unsigned calc_word_cnt_w(input int unsigned data_w);
        return clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Input-beat and result handshakes of the streaming popcount.
interface popcount_stream_if
    import popcount_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_sat
    );

endinterface

// File: rtl/popcount_chunk.sv
// Combinational set-bit counter for one CHUNK_W-bit slice of the input word.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter int unsigned CHUNK_W = DEF_CHUNK_W,
    parameter int unsigned CNT_W   = calc_chunk_cnt_w(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] i_data,
    output logic [CNT_W-1:0]   o_count_c
);

    always_comb begin
        o_count_c = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            o_count_c = o_count_c + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount: stage 1 registers per-chunk counts, stage 2
// sums them and emits per-word counts or saturating per-packet totals.
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CHUNK_W = DEF_CHUNK_W,
    parameter int unsigned ACC_W   = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    popcount_stream_if.slave bus
);

    localparam int unsigned CHUNKS      = calc_chunks(DATA_W, CHUNK_W);
    localparam int unsigned CHUNK_CNT_W = calc_chunk_cnt_w(CHUNK_W);
    localparam int unsigned WORD_CNT_W  = calc_word_cnt_w(DATA_W);

    if (((DATA_W % CHUNK_W) != 0) || (ACC_W < WORD_CNT_W)) begin : g_param_err
        $error("popcount_stream: DATA_W must be a multiple of CHUNK_W and ACC_W must hold DATA_W");
    end

    logic                   w_advance;
    logic [CHUNK_CNT_W-1:0] w_chunk_cnt [CHUNKS];
    logic [CHUNK_CNT_W-1:0] r_s1_cnt    [CHUNKS];
    logic                   r_s1_valid;
    logic                   r_s1_mode;
    logic                   r_s1_last;

    logic [WORD_CNT_W-1:0]  w_word_cnt;
    logic [ACC_W:0]         w_acc_sum;
    logic                   w_acc_ovf;
    logic [ACC_W-1:0]       w_acc_clamped;

    logic [ACC_W-1:0]       r_acc;
    logic                   r_acc_sat;
    logic                   r_out_valid;
    logic [ACC_W-1:0]       r_out_count;
    logic                   r_out_sat;

    logic [ACC_W-1:0]       w_acc_nxt;
    logic                   w_acc_sat_nxt;
    logic                   w_out_valid_nxt;
    logic [ACC_W-1:0]       w_out_count_nxt;
    logic                   w_out_sat_nxt;

    // The whole pipeline moves together whenever the result slot can drain.
    assign w_advance    = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
        popcount_chunk #(
            .CHUNK_W (CHUNK_W),
            .CNT_W   (CHUNK_CNT_W)
        ) u_chunk (
            .i_data    (bus.in_data[g*CHUNK_W +: CHUNK_W]),
            .o_count_c (w_chunk_cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_WORD;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < CHUNKS; i++) begin
                r_s1_cnt[i] <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            r_s1_mode  <= bus.in_mode;
            r_s1_last  <= bus.in_last;
            r_s1_cnt   <= w_chunk_cnt;
        end
    end

    always_comb begin
        w_word_cnt = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            w_word_cnt = w_word_cnt + WORD_CNT_W'(r_s1_cnt[i]);
        end
    end

    // One spare bit catches the carry; overflow clamps to all-ones.
    always_comb begin
        w_acc_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_word_cnt);
        w_acc_ovf     = w_acc_sum[ACC_W];
        w_acc_clamped = w_acc_ovf ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
    end

    always_comb begin
        w_acc_nxt       = r_acc;
        w_acc_sat_nxt   = r_acc_sat;
        w_out_valid_nxt = r_out_valid;
        w_out_count_nxt = r_out_count;
        w_out_sat_nxt   = r_out_sat;
        if (w_advance) begin
            w_out_valid_nxt = 1'b0;
            if (r_s1_valid) begin
                if (r_s1_mode == MODE_WORD) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_count_nxt = ACC_W'(w_word_cnt);
                    w_out_sat_nxt   = 1'b0;
                end else if (r_s1_last) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_count_nxt = w_acc_clamped;
                    w_out_sat_nxt   = r_acc_sat | w_acc_ovf;
                    w_acc_nxt       = '0;
                    w_acc_sat_nxt   = 1'b0;
                end else begin
                    w_acc_nxt     = w_acc_clamped;
                    w_acc_sat_nxt = r_acc_sat | w_acc_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_acc_sat   <= w_acc_sat_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_sat   <= w_out_sat_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_out_count;
    assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream (ACC_W=8 so saturation is reachable):
// directed scenarios with literal expectations plus a randomized stream.
module tb_popcount_stream;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CHUNK_W = 8;
    localparam int unsigned ACC_W   = 8;
    localparam int unsigned SAT_MAX = (1 << ACC_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    popcount_stream_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    popcount_stream #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHUNK_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int unsigned cnt; bit sat; } exp_t;
    typedef struct { int unsigned cnt; bit sat; int unsigned edge_n; } log_t;

    exp_t        exp_q[$];
    log_t        log_q[$];
    int unsigned acc_edge_q[$];
    int unsigned m_acc  = 0;
    int unsigned edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rand_done = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference: results in acceptance order; packets summed exactly, clamped at the end.
    always @(negedge clk) begin
        int unsigned wc;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            m_acc = 0;
        end else begin
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got count=%0d sat=%b, required no output", bus.out_count, bus.out_sat);
                end else if (bus.out_count !== ACC_W'(exp_q[0].cnt) || bus.out_sat !== exp_q[0].sat) begin
                    errors++;
                    $display("FAIL out_result: got count=%0d sat=%b, required count=%0d sat=%b",
                             bus.out_count, bus.out_sat, exp_q[0].cnt, exp_q[0].sat);
                end
                if (bus.out_ready === 1'b1) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    log_q.push_back('{32'(bus.out_count), bus.out_sat, edge_n + 1});
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                acc_edge_q.push_back(edge_n + 1);
                wc = 32'($countones(bus.in_data));
                if (bus.in_mode == 1'b0) begin
                    exp_q.push_back('{wc, 1'b0});
                end else begin
                    m_acc += wc;
                    if (bus.in_last) begin
                        exp_q.push_back('{(m_acc > SAT_MAX) ? SAT_MAX : m_acc, m_acc > SAT_MAX});
                        m_acc = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Present one beat and hold it until accepted; returns just after the transfer edge.
    task automatic send(input logic [31:0] d, input logic m, input logic l);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_last  = l;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        acc_edge_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pw_exp[4];
        logic [31:0] d;
        logic        m;
        logic        l;
        pw_exp = '{0, 32, 2, 16};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_sat",   bus.out_sat,   0);
        check("rst_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;

        // Per-word, back-to-back, with exact latency.
        clear_logs();
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h8000_0001, 1'b0, 1'b0);
        send(32'hA5A5_A5A5, 1'b0, 1'b1);
        idle(5);
        check("pw_n", log_q.size(), 4);
        if (log_q.size() == 4 && acc_edge_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("pw_count%0d", i), log_q[i].cnt, pw_exp[i]);
                check($sformatf("pw_latency%0d", i), log_q[i].edge_n - acc_edge_q[i], 2);
            end
        end

        // Three-beat packet.
        clear_logs();
        send(32'h0000_000F, 1'b1, 1'b0);
        send(32'h0000_00FF, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1);
        idle(5);
        check("acc_n", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("acc_count", log_q[0].cnt, 44);
            check("acc_sat",   log_q[0].sat, 0);
        end

        // Saturating packet followed by a clean one.
        clear_logs();
        for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF, 1'b1, (i == 8));
        send(32'h0000_0001, 1'b1, 1'b1);
        idle(5);
        check("sat_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("sat_count",  log_q[0].cnt, 255);
            check("sat_flag",   log_q[0].sat, 1);
            check("post_count", log_q[1].cnt, 1);
            check("post_flag",  log_q[1].sat, 0);
        end

        // Backpressure while streaming per-word beats.
        clear_logs();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'((64'(1) << (i + 1)) - 1), 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                repeat (5) begin
                    check("bp_in_ready",  bus.in_ready,  0);
                    check("bp_out_valid", bus.out_valid, 1);
                    check("bp_out_count", bus.out_count, 1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_n", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("bp_order%0d", i), log_q[i].cnt, i + 1);
        end

        // Per-word beat inside a packet.
        clear_logs();
        send(32'h0000_00FF, 1'b1, 1'b0);
        send(32'h0000_000F, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b1, 1'b1);
        idle(6);
        check("il_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("il_word",   log_q[0].cnt, 4);
            check("il_packet", log_q[1].cnt, 9);
        end

        // Reset mid-packet discards the partial sum.
        clear_logs();
        send(32'h0000_00FF, 1'b1, 1'b0);
        send(32'h0000_00FF, 1'b1, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(32'h0000_0003, 1'b1, 1'b1);
        idle(5);
        check("rstpkt_n", log_q.size(), 1);
        if (log_q.size() == 1) check("rstpkt_count", log_q[0].cnt, 2);

        // Randomized stream against the reference.
        clear_logs();
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    case ($urandom_range(0, 5))
                        0:       d = 32'h0000_0000;
                        1:       d = 32'hFFFF_FFFF;
                        default: d = $urandom;
                    endcase
                    m = 1'($urandom_range(0, 1));
                    l = 1'($urandom_range(0, 5) == 0);
                    if (i == 399) begin
                        m = 1'b1;
                        l = 1'b1;
                    end
                    send(d, m, l);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        idle(8);
        check("rand_drain", exp_q.size(), 0);
        check("rand_outputs_seen", (log_q.size() > 0) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
